parking_access_ctrl_p: RTL
==========================

Name: parking_access_ctrl_p

Overview:
Parametrised next-generation automatic parking access controller. It guards one entry gate using an entrance sensor, a pass-through sensor and a PIN keypad. Over the single-lane controller it adds:
- configurable PIN width and value
- configurable attempt limit
- a gate-open timeout
- lot occupancy tracking with exit sensor and full-lot refusal
It sits between the sensor/keypad front end and the gate actuator and alarm drivers.

Parameters:
PIN_W, 8, PIN width in bits
PIN_VALUE, 8'h57, correct PIN; width PIN_W
MAX_ATTEMPTS, 3, consecutive wrong PINs that trigger lockout; must be at least 1
CAPACITY, 16, lot spaces
CNT_W, 5, occupancy width; must satisfy 2^CNT_W > CAPACITY
GATE_TIMEOUT, 32, cycles the gate stays open without sensor_2 before auto-close; must be at least 1

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sensor_1  in  1  car present at entrance
sensor_2  in  1  car passing gate line
exit_sensor  in  1  car leaving lot; counted on rising edge
psswrd_atmpt  in  PIN_W  PIN under test; sampled on the try_psswrd rising edge
try_psswrd  in  1  PIN submit; only the 0->1 edge counts
open_gate  out  1  gate open command
close_gate  out  1  gate close command; always ~open_gate
alarm_1  out  1  wrong-PIN lockout alarm
alarm_2  out  1  tailgate/block alarm
lot_full  out  1  occupancy >= CAPACITY
occupancy  out  CNT_W  cars currently in lot
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - state IDLE, attempts 0, timer 0, occupancy 0
  - open_gate 0, close_gate 1, alarm_1 0, alarm_2 0
  - try_prev 1, so a try_psswrd held high through reset is not an edge
  - exit_prev 1
- Reset mid-operation aborts any state, including LOCKOUT, and clears occupancy.
- Outputs are Moore, decoded from the state register. They change on the clk edge that registers the transition, i.e. one cycle after the input is sampled.
- try_edge = try_psswrd & ~try_prev. exit_edge = exit_sensor & ~exit_prev.
- State encodings: IDLE=0, PIN=1, OPEN=2, BLOCK=3, LOCKOUT=4.
- IDLE (gate closed):
  - sensor_1 & sensor_2 -> BLOCK.
  - Else sensor_1 & ~lot_full -> PIN.
  - sensor_1 & lot_full -> stay IDLE; no PIN accepted.
- PIN (gate closed):
  - sensor_1 & sensor_2 -> BLOCK; attempts unchanged.
  - ~sensor_1 -> IDLE; attempts cleared.
  - try_edge with psswrd_atmpt == PIN_VALUE -> OPEN; attempts cleared; timer cleared.
  - try_edge with a mismatch -> attempts+1. If attempts+1 == MAX_ATTEMPTS -> LOCKOUT; otherwise stay in PIN.
- OPEN (open_gate 1):
  - timer increments every cycle.
  - sensor_1 & sensor_2 -> BLOCK (tailgate); no occupancy change.
  - sensor_2 & ~sensor_1 -> IDLE; occupancy +1, saturating at 2^CNT_W-1.
  - timer == GATE_TIMEOUT-1 with no sensor_2 -> IDLE; no increment.
- BLOCK (alarm_2 1, gate closed):
  - try_edge with the correct PIN -> IDLE; alarm_2 clears on entering IDLE.
  - try_edge with a wrong PIN -> stay in BLOCK; attempts not counted.
  - Sensors are ignored.
- LOCKOUT (alarm_1 1, gate closed): all inputs ignored except exit_sensor. Exit only via rst.
- Occupancy:
  - exit_edge decrements in any state, saturating at 0.
  - Increment and exit_edge in the same cycle leave occupancy unchanged.
- lot_full and occupancy are registered and updated together.
- Within a state, priority is BLOCK condition > sensor_1 loss > try_edge > timeout.

Test Plan:
1. rst; sensor_1=1; psswrd_atmpt=8'h57; try 0->1; sensor_1=0; sensor_2=1 -> PIN, then OPEN with open_gate=1, then IDLE with occupancy=1 and close_gate=1.
2. In PIN: 8'h5F submitted twice, then 8'h57 -> attempts reach 2, alarm_1 stays 0, OPEN reached. Gate left idle -> after exactly 32 cycles in OPEN, returns to IDLE with occupancy unchanged.
3. Three 8'h5F submissions in PIN -> LOCKOUT, alarm_1=1. A further 8'h57 is ignored. rst -> IDLE, alarm_1=0, occupancy=0.
4. sensor_1=sensor_2=1 in IDLE -> BLOCK, alarm_2=1. 8'h5F submitted -> stays in BLOCK. 8'h57 with try held high for several cycles -> a single transition to IDLE, alarm_2=0.
5. CAPACITY=2: two full entries -> lot_full=1. sensor_1=1 -> stays IDLE. exit_sensor pulse -> occupancy=1, lot_full=0, and the next sensor_1 enters PIN.
6. Entry increment and exit_edge on the same cycle -> occupancy unchanged. exit_edge at occupancy 0 -> occupancy stays 0. try_psswrd held high across reset release -> no attempt counted.

Source files
------------

// File: rtl/parking_access_ctrl_p.sv
// -----------------------------------------------------------------------------
// parking_access_ctrl_p
//   Entry-gate controller for a parking lot. A car at the entrance (sensor_1)
//   is asked for a PIN. The correct PIN opens the gate until the car crosses
//   the gate line (sensor_2), or until a timeout expires. Consecutive wrong
//   PINs lock the controller out until reset. Both sensors active together is
//   treated as a tailgate/blocked gate. Lot occupancy is tracked here: entries
//   through the gate count up and exit_sensor rising edges count down. A full
//   lot refuses new entries.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   sensor_1      in   car present at entrance
//   sensor_2      in   car passing the gate line
//   exit_sensor   in   car leaving the lot (rising edge counted)
//   psswrd_atmpt  in   PIN under test, sampled on a try_psswrd rising edge
//   try_psswrd    in   PIN submit strobe (rising edge only)
//   open_gate     out  gate open command
//   close_gate    out  gate close command, always ~open_gate
//   alarm_1       out  wrong-PIN lockout alarm
//   alarm_2       out  tailgate / blocked gate alarm
//   lot_full      out  occupancy >= CAPACITY
//   occupancy     out  cars currently in the lot
//   state_dbg     out  current FSM state encoding
// -----------------------------------------------------------------------------
module parking_access_ctrl_p #(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] PIN_VALUE    = 8'h57,
  parameter int               MAX_ATTEMPTS = 3,
  parameter int               CAPACITY     = 16,
  parameter int               CNT_W        = 5,
  parameter int               GATE_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_1,
  input  logic             sensor_2,
  input  logic             exit_sensor,
  input  logic [PIN_W-1:0] psswrd_atmpt,
  input  logic             try_psswrd,
  output logic             open_gate,
  output logic             close_gate,
  output logic             alarm_1,
  output logic             alarm_2,
  output logic             lot_full,
  output logic [CNT_W-1:0] occupancy,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PIN     = 3'd1;
  localparam logic [2:0] OPEN    = 3'd2;
  localparam logic [2:0] BLOCK   = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);

  // "attempts == ATT_LAST" is the same test as "attempts+1 == MAX_ATTEMPTS"
  // without needing an extra bit for the sum.
  localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(MAX_ATTEMPTS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] OCC_ONE  = CNT_W'(1);

  logic [2:0]       state, state_n;
  logic [ATT_W-1:0] attempts, attempts_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] occ_n;
  logic             try_prev, exit_prev;
  logic             try_edge, exit_edge, pin_ok, both, entered;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + OCC_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - OCC_ONE;
  endfunction

  assign try_edge  = try_psswrd & ~try_prev;
  assign exit_edge = exit_sensor & ~exit_prev;
  assign pin_ok    = (psswrd_atmpt == PIN_VALUE);
  assign both      = sensor_1 & sensor_2;

  always_comb begin
    state_n    = state;
    attempts_n = attempts;
    timer_n    = timer;
    entered    = 1'b0;
    case (state)
      IDLE: begin
        if (both)                      state_n = BLOCK;
        else if (sensor_1 && !lot_full) state_n = PIN;
      end
      PIN: begin
        if (both) begin
          state_n = BLOCK;
        end else if (!sensor_1) begin
          state_n    = IDLE;
          attempts_n = '0;
        end else if (try_edge) begin
          if (pin_ok) begin
            state_n    = OPEN;
            attempts_n = '0;
            timer_n    = '0;
          end else begin
            attempts_n = attempts + ATT_W'(1);
            if (attempts == ATT_LAST) state_n = LOCKOUT;
          end
        end
      end
      OPEN: begin
        timer_n = timer + TMR_W'(1);
        if (both) begin
          state_n = BLOCK;
        end else if (sensor_2) begin
          // sensor_2 without sensor_1: the car has crossed into the lot
          state_n = IDLE;
          entered = 1'b1;
        end else if (timer == TMR_LAST) begin
          state_n = IDLE;
        end
      end
      BLOCK: begin
        // Only the correct PIN clears a block; wrong PINs are not counted here.
        if (try_edge && pin_ok) state_n = IDLE;
      end
      LOCKOUT: state_n = LOCKOUT;
      default: state_n = IDLE;
    endcase
  end

  // An entry and an exit in the same cycle cancel out.
  always_comb begin
    occ_n = occupancy;
    if (entered && !exit_edge)      occ_n = sat_inc(occupancy);
    else if (exit_edge && !entered) occ_n = sat_dec(occupancy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      attempts  <= '0;
      timer     <= '0;
      occupancy <= '0;
      lot_full  <= 1'b0;
      // High after reset so a strobe held through reset is not an edge.
      try_prev  <= 1'b1;
      exit_prev <= 1'b1;
    end else begin
      state     <= state_n;
      attempts  <= attempts_n;
      timer     <= timer_n;
      occupancy <= occ_n;
      lot_full  <= (occ_n >= CAP_C);
      try_prev  <= try_psswrd;
      exit_prev <= exit_sensor;
    end
  end

  assign open_gate  = (state == OPEN);
  assign close_gate = ~open_gate;
  assign alarm_1    = (state == LOCKOUT);
  assign alarm_2    = (state == BLOCK);
  assign state_dbg  = state;

endmodule
